// File: rtl/accum_zone_rr.sv
// Multi-slot accumulate scratchpad: round-robin write/read ports with a
// 3-stage read-modify-write path and a fixed 2-cycle read return.
module accum_zone_rr #(
    parameter int NUM_SLOTS  = 4,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_SLOTS-1:0]                      wr_valid,
    output logic [NUM_SLOTS-1:0]                      wr_ready,
    input  logic [NUM_SLOTS*ADDR_WIDTH-1:0]           wr_addr,
    input  logic [NUM_SLOTS*NUM_BANKS-1:0]            wr_mask,
    input  logic [NUM_SLOTS-1:0]                      accum_en,
    input  logic [NUM_SLOTS*NUM_BANKS*DATA_WIDTH-1:0] wdata,
    input  logic [NUM_SLOTS-1:0]                      rd_valid,
    output logic [NUM_SLOTS-1:0]                      rd_ready,
    input  logic [NUM_SLOTS*ADDR_WIDTH-1:0]           rd_addr,
    input  logic [NUM_SLOTS*NUM_BANKS-1:0]            rd_mask,
    output logic [NUM_SLOTS-1:0]                      rvalid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]           rdata,
    input  logic [1:0]                                lane_mode,
    input  logic                                      sat_en,
    output logic                                      busy
);

    localparam int SW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int DW    = DATA_WIDTH;
    localparam int RW    = NUM_BANKS * DATA_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    function automatic logic [NUM_SLOTS-1:0] rr_pick(
        input logic [NUM_SLOTS-1:0] req,
        input logic [SW-1:0]        ptr
    );
        logic [NUM_SLOTS-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            idx = (int'(ptr) + k) % NUM_SLOTS;
            if (req[idx] && (g == '0)) g[idx] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [SW-1:0] enc(input logic [NUM_SLOTS-1:0] oh);
        logic [SW-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_SLOTS; k++)
            if (oh[k]) r = SW'(k);
        return r;
    endfunction

    function automatic logic [DW-1:0] lane_add(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [1:0]    m,
        input logic          sat
    );
        logic [DW-1:0] r8, r16, r32, rf, res;
        logic [8:0]    t8;
        logic [16:0]   t16;
        logic [32:0]   t32;
        logic [DW:0]   tf;
        r8  = '0;
        r16 = '0;
        r32 = '0;
        for (int i = 0; i < DW / 8; i++) begin
            t8 = {1'b0, a[i*8 +: 8]} + {1'b0, b[i*8 +: 8]};
            r8[i*8 +: 8] = (sat && t8[8]) ? 8'hFF : t8[7:0];
        end
        for (int i = 0; i < DW / 16; i++) begin
            t16 = {1'b0, a[i*16 +: 16]} + {1'b0, b[i*16 +: 16]};
            r16[i*16 +: 16] = (sat && t16[16]) ? 16'hFFFF : t16[15:0];
        end
        for (int i = 0; i < DW / 32; i++) begin
            t32 = {1'b0, a[i*32 +: 32]} + {1'b0, b[i*32 +: 32]};
            r32[i*32 +: 32] = (sat && t32[32]) ? 32'hFFFF_FFFF : t32[31:0];
        end
        tf = {1'b0, a} + {1'b0, b};
        rf = (sat && tf[DW]) ? '1 : tf[DW-1:0];
        unique case (m)
            2'd0:    res = r8;
            2'd1:    res = r16;
            2'd2:    res = r32;
            default: res = rf;
        endcase
        return res;
    endfunction

    logic [RW-1:0]         mem_q [DEPTH];
    logic [SW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [NUM_SLOTS-1:0]  wgnt, rgnt, haz;
    logic [SW-1:0]         widx, ridx;

    logic                  s1_v_q, s1_acc_q, s1_sat_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [NUM_BANKS-1:0]  s1_mask_q;
    logic [RW-1:0]         s1_data_q;
    logic [1:0]            s1_mode_q;

    logic                  s2_v_q, s2_acc_q, s2_sat_q;
    logic [ADDR_WIDTH-1:0] s2_addr_q;
    logic [NUM_BANKS-1:0]  s2_mask_q;
    logic [RW-1:0]         s2_data_q, s2_old_q;
    logic [1:0]            s2_mode_q;

    logic                  r1_v_q;
    logic [ADDR_WIDTH-1:0] r1_addr_q;
    logic [NUM_BANKS-1:0]  r1_mask_q;
    logic [NUM_SLOTS-1:0]  r1_slot_q, rv_q;
    logic [RW-1:0]         rdata_q;

    logic [RW-1:0]         new_row, old_d, rrow, rd_row;

    always_comb begin
        haz = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            haz[s] = (s1_v_q && rd_addr[s*ADDR_WIDTH +: ADDR_WIDTH] == s1_addr_q)
                  || (s2_v_q && rd_addr[s*ADDR_WIDTH +: ADDR_WIDTH] == s2_addr_q);
        end
        wgnt   = rst ? '0 : rr_pick(wr_valid, wptr_q);
        rgnt   = rst ? '0 : rr_pick(rd_valid & ~haz, rptr_q);
        widx   = enc(wgnt);
        ridx   = enc(rgnt);
        wptr_d = (|wgnt) ? SW'((int'(widx) + 1) % NUM_SLOTS) : wptr_q;
        rptr_d = (|rgnt) ? SW'((int'(ridx) + 1) % NUM_SLOTS) : rptr_q;
    end

    always_comb begin
        new_row = s2_old_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (s2_mask_q[b]) begin
                if (s2_acc_q)
                    new_row[b*DW +: DW] = lane_add(s2_old_q[b*DW +: DW],
                        s2_data_q[b*DW +: DW], s2_mode_q, s2_sat_q);
                else
                    new_row[b*DW +: DW] = s2_data_q[b*DW +: DW];
            end
        end
    end

    // W2 result bypasses memory so back-to-back accumulates chain without stalls
    always_comb begin
        old_d = (s2_v_q && s2_addr_q == s1_addr_q) ? new_row : mem_q[s1_addr_q];
        rrow  = mem_q[r1_addr_q];
        rd_row = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (r1_mask_q[b]) rd_row[b*DW +: DW] = rrow[b*DW +: DW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
            r1_v_q  <= 1'b0;
            rv_q    <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            s1_v_q <= |wgnt;
            if (|wgnt) begin
                s1_addr_q <= wr_addr[widx*ADDR_WIDTH +: ADDR_WIDTH];
                s1_mask_q <= wr_mask[widx*NUM_BANKS +: NUM_BANKS];
                s1_acc_q  <= accum_en[widx];
                s1_data_q <= wdata[widx*RW +: RW];
                s1_mode_q <= lane_mode;
                s1_sat_q  <= sat_en;
            end
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_addr_q <= s1_addr_q;
                s2_mask_q <= s1_mask_q;
                s2_acc_q  <= s1_acc_q;
                s2_data_q <= s1_data_q;
                s2_mode_q <= s1_mode_q;
                s2_sat_q  <= s1_sat_q;
                s2_old_q  <= old_d;
            end
            r1_v_q <= |rgnt;
            if (|rgnt) begin
                r1_addr_q <= rd_addr[ridx*ADDR_WIDTH +: ADDR_WIDTH];
                r1_mask_q <= rd_mask[ridx*NUM_BANKS +: NUM_BANKS];
                r1_slot_q <= rgnt;
            end
            rv_q    <= r1_v_q ? r1_slot_q : '0;
            rdata_q <= r1_v_q ? rd_row : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && s2_v_q) mem_q[s2_addr_q] <= new_row;
    end

    assign wr_ready = wgnt;
    assign rd_ready = rgnt;
    assign rvalid   = rst ? '0 : rv_q;
    assign rdata    = rst ? '0 : rdata_q;
    assign busy     = !rst && (s1_v_q || s2_v_q || r1_v_q || (|rv_q));

endmodule

// File: tb/tb_accum_zone_rr.sv
// Scoreboard bench for accum_zone_rr: reference row model updated at
// commit time, expected read returns queued at grant and popped on rvalid.
module tb_accum_zone_rr;

    localparam int N  = 4;
    localparam int B  = 4;
    localparam int AW = 9;
    localparam int DW = 64;
    localparam int RW = B * DW;
    localparam logic [3:0] F = 4'hF;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  wr_valid, wr_ready, accum_en, rd_valid, rd_ready, rvalid;
    logic [N*AW-1:0] wr_addr, rd_addr;
    logic [N*B-1:0]  wr_mask, rd_mask;
    logic [N*RW-1:0] wdata;
    logic [RW-1:0]   rdata;
    logic [1:0]      lane_mode;
    logic            sat_en, busy;

    always #5 clk = ~clk;

    accum_zone_rr #(.NUM_SLOTS(N), .NUM_BANKS(B), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .accum_en(accum_en), .wdata(wdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_mask(rd_mask), .rvalid(rvalid), .rdata(rdata),
        .lane_mode(lane_mode), .sat_en(sat_en), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ecnt  = 0;

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]    slot;
        logic [RW-1:0] data;
        int            due;
    } rd_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [B-1:0]  mask;
        logic          acc;
        logic [RW-1:0] data;
        logic [1:0]    mode;
        logic          sat;
        int            at;
    } wr_t;

    rd_t rq[$];
    wr_t wq[$];
    logic [RW-1:0] mdl [int];

    function automatic logic [RW-1:0] mrd(input logic [AW-1:0] a);
        return mdl.exists(int'(a)) ? mdl[int'(a)] : '0;
    endfunction

    function automatic logic [63:0] m_acc(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] m, input logic sat);
        int L;
        longint unsigned x, y, s, lim;
        logic [63:0] r;
        L = 8 << m;
        r = '0;
        lim = (L == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << L) - 64'd1);
        for (int i = 0; i < 64 / L; i++) begin
            x = (a >> (i * L)) & lim;
            y = (b >> (i * L)) & lim;
            s = (x + y) & lim;
            if (sat && s < x) s = lim;
            r = r | (s << (i * L));
        end
        return r;
    endfunction

    task automatic commit(input wr_t w);
        logic [RW-1:0] row;
        row = mrd(w.addr);
        for (int b = 0; b < B; b++) begin
            if (w.mask[b])
                row[b*DW +: DW] = w.acc ? m_acc(row[b*DW +: DW], w.data[b*DW +: DW], w.mode, w.sat)
                                        : w.data[b*DW +: DW];
        end
        mdl[int'(w.addr)] = row;
    endtask

    // inputs only change just after posedge, so negedge sees what the next edge takes
    always @(negedge clk) begin
        rd_t e;
        wr_t w;
        if (rst) begin
            rq.delete();
            wq.delete();
        end else begin
            if (rq.size() > 0 && rq[0].due == ecnt) begin
                chk("sb_slot", 256'(rvalid), 256'(rq[0].slot));
                chk("sb_data", rdata, rq[0].data);
                void'(rq.pop_front());
            end else if (rvalid != '0) begin
                chk("sb_spur", 256'(rvalid), '0);
            end
            while (wq.size() > 0 && wq[0].at == ecnt) begin
                commit(wq[0]);
                void'(wq.pop_front());
            end
            for (int s = 0; s < N; s++) begin
                if (rd_valid[s] && rd_ready[s]) begin
                    e.slot = 4'(1 << s);
                    e.data = mrd(rd_addr[s*AW +: AW]);
                    for (int b = 0; b < B; b++)
                        if (!rd_mask[s*B + b]) e.data[b*DW +: DW] = '0;
                    e.due = ecnt + 2;
                    rq.push_back(e);
                end
            end
            for (int s = 0; s < N; s++) begin
                if (wr_valid[s] && wr_ready[s]) begin
                    w.addr = wr_addr[s*AW +: AW];
                    w.mask = wr_mask[s*B +: B];
                    w.acc  = accum_en[s];
                    w.data = wdata[s*RW +: RW];
                    w.mode = lane_mode;
                    w.sat  = sat_en;
                    w.at   = ecnt + 2;
                    wq.push_back(w);
                end
            end
        end
        ecnt++;
    end

    function automatic logic [RW-1:0] rep(input logic [DW-1:0] v);
        return {B{v}};
    endfunction

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] r;
        for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input int s, input logic [AW-1:0] a, input logic [B-1:0] m,
                         input logic acc, input logic [RW-1:0] d,
                         input logic [1:0] lm, input logic sat);
        wr_valid = '0;
        wr_valid[s] = 1'b1;
        wr_addr[s*AW +: AW] = a;
        wr_mask[s*B +: B] = m;
        accum_en[s] = acc;
        wdata[s*RW +: RW] = d;
        lane_mode = lm;
        sat_en = sat;
        @(negedge clk);
        chk("wgnt", 256'(wr_ready), 256'(1 << s));
        step();
        wr_valid = '0;
    endtask

    task automatic do_rd(input int s, input logic [AW-1:0] a, input logic [B-1:0] m,
                         input logic [RW-1:0] exp, output int stalls);
        rd_valid = '0;
        rd_valid[s] = 1'b1;
        rd_addr[s*AW +: AW] = a;
        rd_mask[s*B +: B] = m;
        stalls = 0;
        @(negedge clk);
        while (!rd_ready[s] && stalls < 10) begin
            stalls++;
            @(negedge clk);
        end
        chk("rgnt", 256'(rd_ready), 256'(1 << s));
        step();
        rd_valid = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rvalid", 256'(rvalid), 256'(1 << s));
        chk("rdata", rdata, exp);
        step();
    endtask

    initial begin
        int st;
        int e0[4] = '{0, 1, 2, 3};
        int e1[4] = '{1, 2, 3, 1};

        rst = 1'b1;
        wr_valid = '1;
        rd_valid = '1;
        wr_addr = '0;
        rd_addr = '0;
        wr_mask = '0;
        rd_mask = '1;
        accum_en = '0;
        wdata = '0;
        lane_mode = 2'd0;
        sat_en = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("rst_wrdy", 256'(wr_ready), '0);
        chk("rst_rrdy", 256'(rd_ready), '0);
        chk("rst_rvalid", 256'(rvalid), '0);
        chk("rst_busy", 256'(busy), '0);
        chk("rst_rdata", rdata, '0);
        step();
        rst = 1'b0;
        rd_valid = '0;

        // round-robin order with all slots requesting, then slot 0 drops out
        for (int s = 0; s < N; s++) wr_addr[s*AW +: AW] = 9'h50 + 9'(s);
        wr_valid = '1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wrr_all", 256'(wr_ready), 256'(1 << e0[i]));
            step();
        end
        wr_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wrr_no0", 256'(wr_ready), 256'(1 << e1[i]));
            step();
        end
        wr_valid = '0;

        do_wr(0, 9'h20, F, 1'b0, '0, 2'd3, 1'b0);
        do_wr(0, 9'h30, F, 1'b0, {64'hD3, 64'hC2, 64'hB1, 64'hA0}, 2'd3, 1'b0);
        do_wr(0, 9'h40, F, 1'b0, rep(64'h4444), 2'd3, 1'b0);

        // 16-bit lanes, wrap then saturate; lane_mode changes while in flight
        do_wr(0, 9'h10, F, 1'b0, rep(64'h0001_0002_0003_FFFF), 2'd1, 1'b0);
        @(negedge clk);
        chk("busy", 256'(busy), 256'(1));
        step();
        do_wr(1, 9'h10, F, 1'b1, rep(64'h2), 2'd1, 1'b0);
        lane_mode = 2'd0;
        sat_en = 1'b1;
        do_rd(0, 9'h10, F, rep(64'h0001_0002_0003_0001), st);
        do_wr(0, 9'h10, F, 1'b0, rep(64'h0001_0002_0003_FFFF), 2'd1, 1'b0);
        do_wr(1, 9'h10, F, 1'b1, rep(64'h2), 2'd1, 1'b1);
        lane_mode = 2'd0;
        sat_en = 1'b0;
        do_rd(0, 9'h10, F, rep(64'h0001_0002_0003_FFFF), st);

        // back-to-back accumulates, no write stall
        do_wr(0, 9'h20, F, 1'b1, rep(64'h1), 2'd3, 1'b0);
        do_wr(1, 9'h20, F, 1'b1, rep(64'h1), 2'd3, 1'b0);
        do_wr(2, 9'h20, F, 1'b1, rep(64'h1), 2'd3, 1'b0);
        do_rd(3, 9'h20, F, rep(64'h3), st);

        do_wr(0, 9'h20, F, 1'b0, rep(64'h77), 2'd3, 1'b0);
        do_rd(1, 9'h20, F, rep(64'h77), st);
        chk("haz_stall", 256'(st), 256'(2));

        do_rd(2, 9'h30, 4'b0101, {64'h0, 64'hC2, 64'h0, 64'hA0}, st);
        do_rd(1, 9'h30, 4'b0000, '0, st);
        do_wr(0, 9'h30, 4'b1000, 1'b0, rep(64'hEE), 2'd3, 1'b0);
        do_rd(0, 9'h30, F, {64'hEE, 64'hC2, 64'hB1, 64'hA0}, st);

        // random concurrent traffic, checked by the scoreboard
        for (int i = 0; i < 8; i++)
            do_wr(i % N, 9'h60 + 9'(i), F, 1'b0, rep(64'(i)), 2'd3, 1'b0);
        for (int c = 0; c < 300; c++) begin
            wr_valid = 4'($urandom & $urandom);
            rd_valid = 4'($urandom);
            accum_en = 4'($urandom);
            wr_mask = 16'($urandom);
            rd_mask = 16'($urandom);
            lane_mode = 2'($urandom);
            sat_en = 1'($urandom);
            for (int s = 0; s < N; s++) begin
                wr_addr[s*AW +: AW] = 9'h60 + 9'($urandom_range(0, 7));
                rd_addr[s*AW +: AW] = 9'h60 + 9'($urandom_range(0, 7));
                wdata[s*RW +: RW] = rnd_row();
            end
            step();
        end
        wr_valid = '0;
        rd_valid = '0;
        repeat (6) step();
        chk("drain", 256'(rq.size()), '0);

        // reset while a write sits in W2: it must not land, pointers restart
        do_rd(2, 9'h40, F, rep(64'h4444), st);
        do_wr(0, 9'h40, F, 1'b0, rep(64'h9999), 2'd3, 1'b0);
        step();
        rst = 1'b1;
        wr_valid = '1;
        @(negedge clk);
        chk("rst2_busy", 256'(busy), '0);
        chk("rst2_wrdy", 256'(wr_ready), '0);
        step();
        rst = 1'b0;
        wr_mask = '0;
        for (int s = 0; s < N; s++) begin
            wr_addr[s*AW +: AW] = 9'h50;
            rd_addr[s*AW +: AW] = 9'h30;
        end
        rd_valid = '1;
        @(negedge clk);
        chk("rst2_wgnt", 256'(wr_ready), 256'(1));
        chk("rst2_rgnt", 256'(rd_ready), 256'(1));
        step();
        wr_valid = '0;
        rd_valid = '0;
        do_rd(0, 9'h40, F, rep(64'h4444), st);
        repeat (4) step();
        chk("drain2", 256'(rq.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
